fsm_step_driver: RTL and testbench
==================================

Name: fsm_step_driver

Overview:
Stimulus/initiator side of the 2-bit step-code interface consumed by the team's 4-state step FSM (state k advances only when in_signal == (k+1) mod 4; its out_signal reports (k+1) mod 4).
- On command, drives exactly num_steps advancing codes, one step at a time, into the FSM's in_signal.
- Confirms each advance on the FSM's out_signal.
- Holds a non-advancing code between steps.
- Reports completion or timeout to the controlling logic.

Parameters:
CNT_W, 8, width of num_steps and steps_done.
TIMEOUT, 4, max CHECK cycles waiting for the FSM to advance before error (>=1).
GAP, 1, idle cycles between a confirmed step and the next STEP (0 allowed).

Ports:
clk  input  1  clock, all logic on posedge.
reset_n  input  1  synchronous, active-low reset.
start  input  1  begin a sequence; sampled only in IDLE, ignored otherwise.
num_steps  input  CNT_W  number of steps; latched when start is accepted.
fsm_out  input  2  out_signal of the driven FSM.
drive_code  output  2  registered; connects to the FSM's in_signal.
busy  output  1  high in STEP/CHECK/GAP.
done  output  1  one-cycle pulse on successful completion.
error  output  1  sticky timeout flag.
steps_done  output  CNT_W  count of confirmed steps in the current or last sequence.

Behaviour:
- Reset (reset_n low at posedge):
  - state=IDLE; drive_code=2'b00 (non-advancing for FSM STATE_0).
  - busy=0, done=0, error=0, steps_done=0, internal exp=0, timer=0.
  - Reset mid-sequence aborts immediately; no further codes are driven.
- States: IDLE, STEP, CHECK, GAP, DONE. All outputs are registered.
- IDLE:
  - Each cycle, drive_code <= (fsm_out - 1) mod 4. This is the hold code.
  - If start=1:
    - Latch num_steps.
    - Clear error and steps_done.
    - If num_steps == 0, go to DONE.
    - Otherwise go to STEP with exp <= fsm_out and drive_code <= fsm_out (the advancing code).
- STEP (exactly 1 cycle): drive_code holds exp. Next state is CHECK with timer cleared.
- CHECK:
  - drive_code stays exp, which is non-advancing once the FSM has moved.
  - If fsm_out == (exp+1) mod 4:
    - steps_done++.
    - If the new count equals the latched num_steps, go to DONE.
    - Else if GAP == 0, go to STEP (re-sampling exp <= fsm_out).
    - Else go to GAP.
  - Otherwise timer++. When timer reaches TIMEOUT mismatching cycles, set error=1 and go to IDLE.
- GAP: hold drive_code for GAP cycles, then STEP (exp <= fsm_out, drive_code <= fsm_out).
- DONE (1 cycle): done=1, busy=0, then IDLE.
- Arithmetic:
  - All code math is mod 4 (2-bit wrap: 00-1=11, 11+1=00).
  - steps_done never exceeds the latched num_steps.
- Sequence semantics:
  - start during busy/DONE is ignored.
  - fsm_out changes during GAP are not checked; exp is re-sampled at each STEP entry.
- Latency:
  - One step = 2+GAP cycles.
  - With num_steps=N>0, done rises (2+GAP)·N − GAP + 1 cycles after the posedge that accepts start.

Optional Feature:
FSM_DRV_WRAP_CNT_EN
- Defined:
  - Adds output port wraps [CNT_W-1:0], reset 0, cleared on accepted start.
  - Increments on each confirmed step whose new fsm_out == 2'b01, i.e. one full FSM rotation.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
1. Reset, real FSM in STATE_0 (fsm_out=01), GAP=1, start with num_steps=4 → drive_code in STEP cycles = 01,10,11,00; done pulses 12 cycles after start edge; steps_done=4; fsm_out back to 01; error=0.
2. num_steps=0 → done pulses in the cycle after start; drive_code never changes to advancing; steps_done=0.
3. fsm_out tied to 01, TIMEOUT=4 → after STEP, 4 CHECK cycles, then error=1, busy=0, done never pulses; the next start clears error.
4. Pulse start repeatedly while busy during a num_steps=3 run → ignored; exactly 3 steps; steps_done=3.
5. reset_n low during the CHECK of step 2 → next cycle all outputs are at reset values; FSM advanced exactly once more at most; no further steps.
6. GAP=0 with num_steps=8 from STATE_0 → back-to-back STEP/CHECK; done 17 cycles after start; with FSM_DRV_WRAP_CNT_EN, wraps=2.

Source files
------------

// File: rtl/fsm_step_driver.sv
// fsm_step_driver
//   Initiator for the 2-bit step-code interface of the 4-state step FSM.
//   The driven FSM in state k advances only when its in_signal equals
//   (k+1) mod 4. It reports (k+1) mod 4 on its out_signal.
//   On start this block drives num_steps advancing codes, one per step.
//   It confirms each advance on fsm_out and holds a non-advancing code
//   between steps. It reports completion (done) or a timeout (error).
//
// Parameters
//   CNT_W   width of num_steps / steps_done (and wraps)
//   TIMEOUT mismatching CHECK cycles tolerated before error (>= 1)
//   GAP     idle cycles between a confirmed step and the next STEP
//
// Ports
//   clk         clock, posedge
//   reset_n     synchronous active-low reset
//   start       begin a sequence (sampled in IDLE only)
//   num_steps   step count, latched on accepted start
//   fsm_out     out_signal of the driven FSM
//   drive_code  registered code to the FSM's in_signal
//   busy        high while in STEP/CHECK/GAP
//   done        one-cycle pulse after a successful sequence
//   error       sticky timeout flag, cleared on accepted start
//   steps_done  confirmed steps in the current/last sequence
//   wraps       (FSM_DRV_WRAP_CNT_EN only) full FSM rotations seen
//
// Optional feature macro: FSM_DRV_WRAP_CNT_EN
//
// state | meaning
// IDLE  | track hold code fsm_out-1, wait for start
// STEP  | drive the advancing code for one cycle
// CHECK | wait for fsm_out == exp+1, bounded by TIMEOUT
// GAP   | hold code for GAP cycles before the next STEP
// DONE  | sequence complete; done pulses on the following cycle

module fsm_step_driver #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 4,
  parameter int GAP     = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_steps,
  input  logic [1:0]       fsm_out,
  output logic [1:0]       drive_code,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] steps_done
`ifdef FSM_DRV_WRAP_CNT_EN
  ,
  output logic [CNT_W-1:0] wraps
`endif
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STEP  = 3'd1,
    CHECK = 3'd2,
    GAP_S = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       drive_q, drive_d;
  logic [1:0]       exp_q, exp_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [CNT_W-1:0] steps_q, steps_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [GW-1:0]    gap_q, gap_d;
`ifdef FSM_DRV_WRAP_CNT_EN
  logic [CNT_W-1:0] wraps_q, wraps_d;
`endif

  logic [1:0]       hold_code;
  logic [1:0]       exp_next;
  logic [CNT_W-1:0] steps_inc;

  always_comb begin
    hold_code = fsm_out - 2'd1;
    exp_next  = exp_q + 2'd1;
    steps_inc = steps_q + CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    drive_d = drive_q;
    exp_d   = exp_q;
    error_d = error_q;
    steps_d = steps_q;
    num_d   = num_q;
    timer_d = timer_q;
    gap_d   = gap_q;
`ifdef FSM_DRV_WRAP_CNT_EN
    wraps_d = wraps_q;
`endif

    case (state_q)
      IDLE: begin
        drive_d = hold_code;
        if (start) begin
          num_d   = num_steps;
          error_d = 1'b0;
          steps_d = '0;
`ifdef FSM_DRV_WRAP_CNT_EN
          wraps_d = '0;
`endif
          if (num_steps == '0) begin
            state_d = DONE;
          end else begin
            state_d = STEP;
            exp_d   = fsm_out;
            drive_d = fsm_out;
          end
        end
      end

      STEP: begin
        drive_d = exp_q;
        timer_d = '0;
        state_d = CHECK;
      end

      CHECK: begin
        // Once the FSM has moved, exp is one behind it and thus non-advancing.
        drive_d = exp_q;
        if (fsm_out == exp_next) begin
          steps_d = steps_inc;
`ifdef FSM_DRV_WRAP_CNT_EN
          if (fsm_out == 2'b01) wraps_d = wraps_q + CNT_W'(1);
`endif
          if (steps_inc == num_q) begin
            state_d = DONE;
          end else if (GAP == 0) begin
            state_d = STEP;
            exp_d   = fsm_out;
            drive_d = fsm_out;
          end else begin
            state_d = GAP_S;
            gap_d   = '0;
          end
        end else if (timer_q == TO_LAST) begin
          error_d = 1'b1;
          state_d = IDLE;
          drive_d = hold_code;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      GAP_S: begin
        // fsm_out is not checked here; exp is re-sampled on STEP entry.
        if (gap_q == GAP_LAST) begin
          state_d = STEP;
          exp_d   = fsm_out;
          drive_d = fsm_out;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        drive_d = hold_code;
      end
    endcase

    busy_d = (state_d == STEP) || (state_d == CHECK) || (state_d == GAP_S);
    // The pulse follows the DONE cycle so every output stays a plain flop.
    done_d = (state_q == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      drive_q <= 2'b00;
      exp_q   <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
      steps_q <= '0;
      num_q   <= '0;
      timer_q <= '0;
      gap_q   <= '0;
`ifdef FSM_DRV_WRAP_CNT_EN
      wraps_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      drive_q <= drive_d;
      exp_q   <= exp_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
      steps_q <= steps_d;
      num_q   <= num_d;
      timer_q <= timer_d;
      gap_q   <= gap_d;
`ifdef FSM_DRV_WRAP_CNT_EN
      wraps_q <= wraps_d;
`endif
    end
  end

  assign drive_code = drive_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = error_q;
  assign steps_done = steps_q;
`ifdef FSM_DRV_WRAP_CNT_EN
  assign wraps      = wraps_q;
`endif

endmodule

// File: tb/tb_fsm_step_driver.sv
// Bench for fsm_step_driver: dut_a (GAP=1) and dut_b (GAP=0), each driving
// a behavioural model of the 4-state step FSM. dut_a's fsm_out can be tied
// to 01 to force a timeout.

module tb_fsm_step_driver;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset_n, fsm_rst_n, tie_a;
  logic             start_a, start_b;
  logic [CNT_W-1:0] num_a, num_b;
  logic [1:0]       drive_a, drive_b, fsm_out_a, fsm_out_b;
  logic             busy_a, busy_b, done_a, done_b, error_a, error_b;
  logic [CNT_W-1:0] steps_a, steps_b;
`ifdef FSM_DRV_WRAP_CNT_EN
  logic [CNT_W-1:0] wraps_a, wraps_b;
`endif

  logic [1:0] mst_a, mst_b, nxt_a, nxt_b;
  assign nxt_a     = mst_a + 2'd1;
  assign nxt_b     = mst_b + 2'd1;
  assign fsm_out_a = tie_a ? 2'b01 : nxt_a;
  assign fsm_out_b = nxt_b;

  always @(posedge clk) begin
    if (!fsm_rst_n) mst_a <= 2'd0;
    else if (drive_a == nxt_a) mst_a <= nxt_a;
  end

  always @(posedge clk) begin
    if (!fsm_rst_n) mst_b <= 2'd0;
    else if (drive_b == nxt_b) mst_b <= nxt_b;
  end

  fsm_step_driver #(.CNT_W(CNT_W), .TIMEOUT(4), .GAP(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .start(start_a), .num_steps(num_a),
    .fsm_out(fsm_out_a), .drive_code(drive_a), .busy(busy_a), .done(done_a),
    .error(error_a), .steps_done(steps_a)
`ifdef FSM_DRV_WRAP_CNT_EN
    , .wraps(wraps_a)
`endif
  );

  fsm_step_driver #(.CNT_W(CNT_W), .TIMEOUT(4), .GAP(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .start(start_b), .num_steps(num_b),
    .fsm_out(fsm_out_b), .drive_code(drive_b), .busy(busy_b), .done(done_b),
    .error(error_b), .steps_done(steps_b)
`ifdef FSM_DRV_WRAP_CNT_EN
    , .wraps(wraps_b)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [1:0] step_codes [4];

  initial begin
    step_codes[0] = 2'b01;
    step_codes[1] = 2'b10;
    step_codes[2] = 2'b11;
    step_codes[3] = 2'b00;

    reset_n = 1'b0; fsm_rst_n = 1'b0; tie_a = 1'b0;
    start_a = 1'b0; start_b = 1'b0; num_a = '0; num_b = '0;
    repeat (2) @(negedge clk);
    check_val("rst_drive", drive_a, 2'b00);
    check_val("rst_busy", busy_a, 0);
    check_val("rst_done", done_a, 0);
    check_val("rst_error", error_a, 0);
    check_val("rst_steps", steps_a, 0);
    reset_n = 1'b1; fsm_rst_n = 1'b1;
    @(negedge clk);
    check_val("idle_hold", drive_a, 2'b00);

    // 1: four steps from STATE_0, GAP=1; done 12 cycles after accept.
    start_a = 1'b1; num_a = 8'd4;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      if (c == 0 || c == 3 || c == 6 || c == 9)
        check_val("t1_code", drive_a, step_codes[c/3]);
      if (c == 0) check_val("t1_busy", busy_a, 1);
      if (c == 11) check_val("t1_busy_done", busy_a, 0);
      check_val("t1_done", done_a, (c == 12));
    end
    check_val("t1_steps", steps_a, 4);
    check_val("t1_fsm", fsm_out_a, 2'b01);
    check_val("t1_error", error_a, 0);
`ifdef FSM_DRV_WRAP_CNT_EN
    check_val("t1_wraps", wraps_a, 1);
`endif

    // 2: num_steps=0 completes immediately.
    start_a = 1'b1; num_a = 8'd0;
    @(negedge clk);
    start_a = 1'b0;
    check_val("t2_done0", done_a, 0);
    check_val("t2_busy", busy_a, 0);
    check_val("t2_drive0", drive_a, 2'b00);
    check_val("t2_steps", steps_a, 0);
    @(negedge clk);
    check_val("t2_done1", done_a, 1);
    check_val("t2_drive1", drive_a, 2'b00);
    @(negedge clk);
    check_val("t2_done2", done_a, 0);

    // 3: fsm_out stuck at 01 -> timeout after 4 CHECK cycles.
    tie_a = 1'b1;
    start_a = 1'b1; num_a = 8'd2;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      start_a = 1'b0;
      check_val("t3_busy", busy_a, (c < 5));
      check_val("t3_error", error_a, (c >= 5));
      check_val("t3_done", done_a, 0);
    end
    start_a = 1'b1; num_a = 8'd0;
    @(negedge clk);
    start_a = 1'b0;
    check_val("t3_err_clr", error_a, 0);
    @(negedge clk);
    check_val("t3_done_after", done_a, 1);
    fsm_rst_n = 1'b0;
    @(negedge clk);
    fsm_rst_n = 1'b1; tie_a = 1'b0;
    @(negedge clk);

    // 4: start pulses while busy/DONE are ignored.
    start_a = 1'b1; num_a = 8'd3;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      start_a = ((c % 2) == 0) && (c <= 8);
      num_a   = 8'd7;
      check_val("t4_done", done_a, (c == 9));
      if (c >= 10) check_val("t4_busy", busy_a, 0);
    end
    start_a = 1'b0;
    check_val("t4_steps", steps_a, 3);
    check_val("t4_fsm", fsm_out_a, 2'b00);

    // 5: reset during the CHECK of step 2 aborts the sequence.
    start_a = 1'b1; num_a = 8'd4;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      start_a = 1'b0;
    end
    check_val("t5_busy_pre", busy_a, 1);
    check_val("t5_steps_pre", steps_a, 1);
    reset_n = 1'b0;
    @(negedge clk);
    check_val("t5_drive", drive_a, 2'b00);
    check_val("t5_busy", busy_a, 0);
    check_val("t5_done", done_a, 0);
    check_val("t5_error", error_a, 0);
    check_val("t5_steps", steps_a, 0);
`ifdef FSM_DRV_WRAP_CNT_EN
    check_val("t5_wraps", wraps_a, 0);
`endif
    reset_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_val("t5_fsm_hold", fsm_out_a, 2'b10);
      check_val("t5_idle", busy_a, 0);
    end

    // 6: GAP=0, eight back-to-back steps, done 17 cycles after accept.
    start_b = 1'b1; num_b = 8'd8;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      start_b = 1'b0;
      if ((c % 2) == 0 && c < 16)
        check_val("t6_code", drive_b, step_codes[(c/2)%4]);
      check_val("t6_done", done_b, (c == 17));
    end
    check_val("t6_steps", steps_b, 8);
    check_val("t6_fsm", fsm_out_b, 2'b01);
    check_val("t6_error", error_b, 0);
`ifdef FSM_DRV_WRAP_CNT_EN
    check_val("t6_wraps", wraps_b, 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
